// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV64 load/store unit: one operation at a time against a doubleword memory
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_store_data,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_fault,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_address_1,
    output logic [31:0] mem_address_2,
    output logic [63:0] mem_write_value,
    input  logic [63:0] mem_val1
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [63:0] r_sdata;
    logic [63:0] r_word;
    logic [63:0] r_resp_data;
    logic        r_fault;

    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_index;
    logic [5:0]  w_shift;
    logic [63:0] w_lane;
    logic [63:0] w_load;
    logic [63:0] w_merge;

    assign w_accept = req_valid & req_ready;
    assign w_index  = {3'b000, r_addr[31:3]};
    assign w_shift  = {r_addr[2:0], 3'b000};
    assign w_lane   = mem_val1 >> w_shift;

    // Illegal width first, then out-of-range address, then natural alignment.
    always_comb begin
        w_fault = 1'b0;
        if (req_funct3 == 3'b111 || (req_is_store && req_funct3[2])) begin
            w_fault = 1'b1;
        end else if (req_addr[31:28] != 4'h0) begin
            w_fault = 1'b1;
        end else begin
            case (req_funct3[1:0])
                2'b01:   w_fault = req_addr[0];
                2'b10:   w_fault = |req_addr[1:0];
                2'b11:   w_fault = |req_addr[2:0];
                default: w_fault = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_load = 64'h0;
        case (r_funct3)
            3'b000:  w_load = {{56{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_load = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load = {{32{w_lane[31]}}, w_lane[31:0]};
            3'b011:  w_load = mem_val1;
            3'b100:  w_load = {56'h0, w_lane[7:0]};
            3'b101:  w_load = {48'h0, w_lane[15:0]};
            3'b110:  w_load = {32'h0, w_lane[31:0]};
            default: w_load = 64'h0;
        endcase
    end

    // Sub-doubleword stores patch only the addressed lanes of the word read in RD.
    always_comb begin
        w_merge = r_word;
        case (r_funct3[1:0])
            2'b00:   w_merge[w_shift +: 8]  = r_sdata[7:0];
            2'b01:   w_merge[w_shift +: 16] = r_sdata[15:0];
            2'b10:   w_merge[w_shift +: 32] = r_sdata[31:0];
            default: w_merge = r_sdata;
        endcase
    end

    always_comb begin
        w_next          = r_state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_fault      = 1'b0;
        mem_read_en     = 1'b0;
        mem_write_en    = 1'b0;
        mem_address_1   = 32'h0;
        mem_address_2   = 32'h0;
        mem_write_value = 64'h0;
        case (r_state)
            S_IDLE: begin
                req_ready = reset;
                if (w_accept) begin
                    if (w_fault)
                        w_next = S_RESP;
                    else if (req_is_store && req_funct3 == 3'b011)
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD: begin
                mem_read_en   = 1'b1;
                mem_address_1 = w_index;
                mem_address_2 = w_index;
                w_next        = r_is_store ? S_WR : S_RESP;
            end
            S_WR: begin
                mem_write_en    = 1'b1;
                mem_address_1   = w_index;
                mem_address_2   = w_index;
                mem_write_value = w_merge;
                w_next          = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_fault = r_fault;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign resp_data = r_resp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= 32'h0;
            r_sdata     <= 64'h0;
            r_word      <= 64'h0;
            r_resp_data <= 64'h0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_store <= req_is_store;
                r_funct3   <= req_funct3;
                r_addr     <= req_addr;
                r_sdata    <= req_store_data;
                r_fault    <= w_fault;
                if (w_fault)
                    r_resp_data <= 64'h0;
            end
            if (r_state == S_RD) begin
                r_word <= mem_val1;
                if (!r_is_store)
                    r_resp_data <= w_load;
            end
            if (r_state == S_WR)
                r_resp_data <= 64'h0;
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low; 0 clears all state and registered outputs.
REQ-004 req_valid  in  1  core presents a memory operation.
REQ-005 req_ready  out  1  unit can accept; accept = req_valid & req_ready.
REQ-006 req_is_store  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RISC-V width code (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
REQ-008 req_addr  in  32  byte address.
REQ-009 req_store_data  in  64  store source; low bytes used for B/H/W.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_data  out  64  load result; 0 for stores and faults; holds until next resp_valid.
REQ-012 resp_fault  out  1  qualified by resp_valid; misaligned, out-of-range or illegal funct3.
REQ-013 mem_read_en, mem_write_en  out  1 each  data-memory strobes.
REQ-014 mem_address_1, mem_address_2  out  32 each  doubleword index; both carry the same value.
REQ-015 mem_write_value  out  64  doubleword written.
REQ-016 mem_val1  in  64  combinational read data, valid in the same cycle as mem_read_en.

Function
REQ-017 SHALL register req_is_store, req_funct3, req_addr and req_store_data on accept; index = {3'b0, addr[31:3]}, offset = addr[2:0], byte k = bits 8k+7:8k.
REQ-018 SHALL implement FSM IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 Fault check on accept, in priority order: funct3 111, or store with funct3 >= 100 -> fault; addr[31:28] != 0 -> fault; H with addr[0] != 0, W with addr[1:0] != 0, D with addr[2:0] != 0 -> fault.
REQ-020 Transitions: IDLE -> RESP on a faulting accept; IDLE -> WR on an SD accept; IDLE -> RD on any other accept; RD -> RESP for loads; RD -> WR for SB/SH/SW; WR -> RESP; RESP -> IDLE.
REQ-021 Signals in RD: mem_read_en = 1 and the index is driven; mem_val1 is captured into the data register at the end of the cycle.
REQ-022 Signals in WR: mem_write_en = 1 and the index is driven; mem_write_value = store data for SD, otherwise the captured doubleword with only the addressed 1/2/4 bytes replaced by store data bits [7:0]/[15:0]/[31:0].
REQ-023 mem_read_en and mem_write_en SHALL never be 1 in the same cycle; in IDLE and RESP both are 0 and the addresses are 0.
REQ-024 Load extraction: B/H/W sign-extend, BU/HU/WU zero-extend and D passes through, all from the offset lanes.
REQ-025 Latency from accept cycle T: a fault gives resp_valid at T+1; a load gives T+2; SD gives T+2; SB/SH/SW give T+3.
REQ-026 resp_valid SHALL be high exactly during RESP; resp_fault = 1 only with resp_valid; a faulting operation SHALL issue no memory strobe.
REQ-027 req_* changes while not in IDLE SHALL have no effect; back-to-back operations are allowed, with the next accept possible in the cycle after RESP.

Reset
REQ-028 reset = 0 SHALL immediately force state IDLE and clear req_ready, resp_valid, resp_fault, resp_data, both strobes, both addresses and mem_write_value; this includes reset asserted during WR, where the write is abandoned.
REQ-029 In the first cycle after reset release, req_ready SHALL be 1.

Verification
REQ-030 LD: addr 0x10 with mem_val1 = 0x8877665544332211 -> mem_read_en in T+1 with index 2; resp_data 0x8877665544332211 at T+2 with fault 0.
REQ-031 LB vs LBU: addr 0x17 with the same word -> LB returns 0xFFFFFFFFFFFFFF88 and LBU returns 0x0000000000000088.
REQ-032 SH: addr 0x0A with data 0xBEEF over the old word 0x1111111111111111 -> read T+1, then write T+2 of 0x11111111BEEF1111 at index 1; resp at T+3.
REQ-033 Faults -> resp_fault = 1 at T+1 with no strobe:
  - LW at addr 0x6;
  - SD at addr 0x10000000;
  - funct3 111.
REQ-034 Reset pulsed low during the WR of a SB -> mem_write_en falls without waiting for a clock; req_ready = 1 after release; no resp_valid.
